// File: rtl/req_index_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : req_index_encoder
//  Purpose  : Collects up to N_REQ request lines into a sticky pending vector
//             and hands them out one at a time as IDX_W-bit indices over a
//             valid/ready handshake. The presented bit is cleared when its
//             handshake completes. Feeds event/vector numbers to the processor.
//  Ports    : clock      - rising-edge clock
//             reset      - synchronous, active-high reset
//             req        - request lines; bit i high in a cycle marks i pending
//             out_ready  - consumer accepts out_index this cycle
//             out_valid  - out_index holds a pending request
//             out_index  - index of the presented request
//             pending    - registered pending vector
//             dup_flag   - sticky: a request hit an already-pending bit
//  Options  : ROUND_ROBIN_EN - when defined, the next index is searched upward
//             from one past the last accepted index (wrapping), instead of
//             fixed lowest-index-first priority.
//  Revision : 1.0 - initial release
// ============================================================================
module req_index_encoder #(
    parameter int N_REQ = 32,
    parameter int IDX_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_index,
    output logic [N_REQ-1:0] pending,
    output logic             dup_flag
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    localparam logic [N_REQ-1:0] C_ONE_HOT_LSB = {{(N_REQ-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [N_REQ-1:0]   pending_q, pending_d;
    logic               dup_q, dup_d;

    logic               w_hs;
    logic [N_REQ-1:0]   w_clr;
    logic [N_REQ-1:0]   w_remain;
    logic [IDX_W-1:0]   w_start_idle;
    logic [IDX_W-1:0]   w_start_hs;

`ifdef ROUND_ROBIN_EN
    logic [IDX_W-1:0]   last_q, last_d;
`endif

    // First set bit of x, scanning upward from 'start' and wrapping.
    function automatic logic [IDX_W-1:0] sel(
        input logic [N_REQ-1:0] x,
        input logic [IDX_W-1:0] start
    );
        logic [IDX_W-1:0] result;
        logic [IDX_W-1:0] pos;
        logic             found;
        result = '0;
        found  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = start + k[IDX_W-1:0];
            if (!found && x[pos]) begin
                result = pos;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    assign w_hs     = (state_q == PRESENT) && out_ready;
    assign w_clr    = w_hs ? (C_ONE_HOT_LSB << index_q) : '0;
    // Candidates for back-to-back presentation: requests arriving in the
    // handshake cycle are deliberately excluded; they are picked up next cycle.
    assign w_remain = pending_q & ~w_clr;

`ifdef ROUND_ROBIN_EN
    // On a handshake 'last' becomes the accepted index, so the back-to-back
    // search starts just past the index being accepted.
    assign w_start_idle = last_q + 1'b1;
    assign w_start_hs   = index_q + 1'b1;
`else
    assign w_start_idle = '0;
    assign w_start_hs   = '0;
`endif

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        // A new request on the bit being cleared wins, so it stays pending.
        pending_d = w_remain | req;
        dup_d     = dup_q | (|(req & w_remain));
`ifdef ROUND_ROBIN_EN
        last_d    = w_hs ? index_q : last_q;
`endif
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    index_d = sel(pending_q, w_start_idle);
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                // No preemption: index only changes on a completed handshake.
                if (w_hs) begin
                    if (|w_remain) begin
                        index_d = sel(w_remain, w_start_hs);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            index_q   <= '0;
            pending_q <= '0;
            dup_q     <= 1'b0;
`ifdef ROUND_ROBIN_EN
            last_q    <= '1;
`endif
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            pending_q <= pending_d;
            dup_q     <= dup_d;
`ifdef ROUND_ROBIN_EN
            last_q    <= last_d;
`endif
        end
    end

    assign out_valid = (state_q == PRESENT);
    assign out_index = index_q;
    assign pending   = pending_q;
    assign dup_flag  = dup_q;

endmodule
`default_nettype wire

// File: doc/req_index_encoder.md
Name: req_index_encoder

Overview:
- Inverse of the 5-to-32 select decoder: collects up to 32 request lines and returns them, one at a time, as 5-bit indices.
- Each request sets a sticky pending bit. The block presents one pending index at a time through a valid/ready handshake and clears that bit when the handshake completes.
- Serves as the event/interrupt encoding stage ahead of the processor, which consumes the index as a register or vector number.

Parameters:
- N_REQ, 32, number of request lines; only 32 is verified.
- IDX_W, 5, index width; must equal clog2(N_REQ).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req  in  N_REQ  request pulses or levels; bit i set in a cycle marks i pending
- out_ready  in  1  consumer accepts out_index this cycle
- out_valid  out  1  out_index holds a pending request
- out_index  out  IDX_W  index of the presented request
- pending  out  N_REQ  registered pending vector P
- dup_flag  out  1  sticky; a request hit an already-pending bit

Behaviour:
- Interface is fixed: one clock, named clock. Reset port is named reset and is synchronous and active-high.
- Reset:
  - P=0, out_valid=0, out_index=0, dup_flag=0, state IDLE.
  - Reset dominates req and out_ready in the same cycle.
  - Reset mid-handshake discards the presented index and all pending bits.
- Handshake: hs = out_valid & out_ready. clr = one-hot(out_index) when hs, else 0.
- Pending update: P_next = (P & ~clr) | req.
  - If req[i] and clr[i] occur in the same cycle, bit i stays set (new event wins).
- dup_flag is set when (req & P & ~clr) != 0. It is cleared only by reset.
- State machine, two states; out_valid = (state == PRESENT):
  - IDLE:
    - If P != 0: load out_index = sel(P) and go to PRESENT.
    - Otherwise stay in IDLE.
  - PRESENT, no hs: hold out_index. No preemption by higher-priority arrivals.
  - PRESENT, with hs: let R = P & ~clr.
    - If R != 0: out_index = sel(R) and stay in PRESENT (back-to-back, no bubble).
    - Otherwise go to IDLE.
    - req bits arriving in the hs cycle are not part of R; they are seen in the following cycle.
- sel(X): lowest set bit index of X (fixed priority; bit 0 highest).
- Latency:
  - req[i] at cycle n -> P[i]=1 at n+1 -> out_valid=1 with out_index=i at n+2, when idle.
  - One index can be accepted per cycle.
- out_ready while out_valid=0 is ignored.
- All outputs are registered; no combinational path from req or out_ready to outputs.

Optional Feature:
- Macro ROUND_ROBIN_EN.
- Defined:
  - sel(X) searches upward from (last + 1) mod 32, wrapping past 31 to 0.
  - last is a 5-bit register updated to out_index on each hs.
  - Reset sets last=31, so the first search starts at bit 0.
- Undefined: fixed lowest-index priority as above; no last register.

Test Plan:
- Reset, then req=0x0000_0001 for 1 cycle, out_ready=1 -> out_valid rises 2 cycles later with out_index=0; the next cycle gives out_valid=0 and pending=0.
- req=0x8000_0011 for 1 cycle, out_ready=1 continuously -> indices 0, 4, 31 on three consecutive cycles, then out_valid=0. With ROUND_ROBIN_EN the order is the same.
- req=0x0000_0020 with out_ready=0 -> out_valid=1, out_index=5. Then req=0x0000_0001 -> out_index stays 5 until out_ready=1, then 0 is presented the next cycle.
- While out_index=3 is handshaking, req=0x0000_0008 in the same cycle -> pending[3] remains 1, dup_flag stays 0, and index 3 is re-presented.
- With pending[7]=1, req=0x0000_0080 again -> dup_flag=1 and stays 1 until reset. With reset=1 and req=0xFFFF_FFFF in the same cycle -> pending=0, out_valid=0, dup_flag=0.
- ROUND_ROBIN_EN: pending=0x0000_0003, grant 0, then req[0] re-asserted -> next index 1, then 0. Without the macro -> 0 then 1 order preserved by priority (0 first).
